// File: rtl/types.sv
`default_nettype none
// ============================================================================
//  Module   : types (package)
//  Purpose  : Shared pixel/header types, constants and FSM encoding for the
//             block packer.
//  Revision : 1.0  initial release
// ============================================================================
package types;

    localparam int NUM_PIXELS = 32;
    localparam int WORD_W     = 32;
    localparam int MAX_CH_W   = 8;

    // Field order puts r in the low byte, so a pixel reads as {a, b, g, r}.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef pixel_t [NUM_PIXELS-1:0] pixels_t;

    // Per-channel arrays are indexed 0=R, 1=G, 2=B, 3=A.
    typedef struct packed {
        logic             compressable;
        logic [3:0][3:0]  width;
        logic [3:0][7:0]  min;
    } pack_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR0    = 2'd1,
        ST_HDR1    = 2'd2,
        ST_PAYLOAD = 2'd3
    } pack_state_t;

    // Select one colour byte of a pixel by channel index.
    function automatic logic [7:0] chan_byte(input pixel_t p, input logic [1:0] ch);
        logic [7:0] b;
        case (ch)
            2'd0:    b = p.r;
            2'd1:    b = p.g;
            2'd2:    b = p.b;
            default: b = p.a;
        endcase
        return b;
    endfunction

endpackage : types
`default_nettype wire

// File: rtl/bit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : bit_accumulator
//  Purpose  : 40-bit LSB-first bit collector. Appends up to 8 bits per cycle
//             at the current fill point and pops 32-bit words from the bottom.
//             Pop and append may coincide: pop happens first.
//  Revision : 1.0  initial release
// ============================================================================
module bit_accumulator
    import types::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               append,
    input  logic [MAX_CH_W-1:0] data,
    input  logic [3:0]         width,
    input  logic               pop,
    output logic [WORD_W-1:0]  word,
    output logic               word_valid
);

    logic [39:0] r_acc;
    logic [5:0]  r_fill;

    logic [39:0] w_base_acc;
    logic [5:0]  w_base_fill;
    logic [7:0]  w_mask;
    logic [39:0] w_ext;
    logic [39:0] w_next_acc;
    logic [5:0]  w_next_fill;

    // Pop first (shift out the low word), then place the masked residual
    // directly above the remaining valid bits.
    always_comb begin
        w_base_acc  = pop ? (r_acc >> 32) : r_acc;
        w_base_fill = pop ? (r_fill - 6'd32) : r_fill;
        w_mask      = (width >= 4'd8) ? 8'hFF : 8'((8'd1 << width) - 8'd1);
        w_ext       = {32'd0, data & w_mask};
        w_next_acc  = w_base_acc;
        w_next_fill = w_base_fill;
        if (append) begin
            w_next_acc  = w_base_acc | (w_ext << w_base_fill);
            w_next_fill = w_base_fill + {2'b00, width};
        end
    end

    // Accumulator register and fill count; clear discards any leftover bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else begin
            r_acc  <= w_next_acc;
            r_fill <= w_next_fill;
        end
    end

    assign word       = r_acc[WORD_W-1:0];
    assign word_valid = (r_fill >= 6'd32);

endmodule : bit_accumulator
`default_nettype wire

// File: rtl/block_packer.sv
`default_nettype none
// ============================================================================
//  Module   : block_packer
//  Purpose  : Serialises one 32-pixel RGBA block plus header into 32-bit words
//             (two header words, then bit-packed residuals or raw pixels)
//             under valid/ready flow control.
//  Revision : 1.0  initial release
// ============================================================================
module block_packer
    import types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  pixels_t             in_pixels,
    input  logic [3:0][7:0]     in_min,
    input  logic [3:0][3:0]     in_width,
    input  logic                in_compressable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last
);

    pack_state_t       r_state;
    pixels_t           r_pixels;
    pack_hdr_t         r_hdr;
    logic [1:0]        r_ch;
    logic [4:0]        r_px;
    logic              r_app_done;
    logic [5:0]        r_wcnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_last;

    logic              w_accept;
    logic [5:0]        w_npay;
    logic              w_stall;
    logic              w_final_hs;
    logic              w_in_pay;
    logic              w_want_word;
    logic              w_pop;
    logic              w_raw_word;
    logic              w_append;
    logic [7:0]        w_res;
    logic [WORD_W-1:0] w_acc_word;
    logic              w_acc_valid;

    // Handshake and sequencing decisions shared by the FSM and the walker.
    always_comb begin
        w_accept    = r_in_ready && in_valid;
        w_npay      = r_hdr.compressable
                      ? ({2'b00, r_hdr.width[0]} + {2'b00, r_hdr.width[1]} +
                         {2'b00, r_hdr.width[2]} + {2'b00, r_hdr.width[3]})
                      : 6'(NUM_PIXELS);
        w_stall     = r_out_valid && !out_ready;
        w_final_hs  = r_out_valid && r_out_last && out_ready;
        w_in_pay    = (r_state == ST_HDR1) || (r_state == ST_PAYLOAD);
        w_want_word = w_in_pay && !w_stall && !w_final_hs && (r_wcnt != w_npay);
        w_pop       = w_want_word && r_hdr.compressable && w_acc_valid;
        w_raw_word  = w_want_word && !r_hdr.compressable;
        // Appends run from HDR0 onward so residuals overlap header output;
        // only append when the result cannot push fill past 39.
        w_append    = (r_state != ST_IDLE) && r_hdr.compressable && !r_app_done &&
                      !w_stall && (!w_acc_valid || w_pop);
        w_res       = chan_byte(r_pixels[r_px], r_ch) - r_hdr.min[r_ch];
    end

    bit_accumulator u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_accept),
        .append     (w_append),
        .data       (w_res),
        .width      (r_hdr.width[r_ch]),
        .pop        (w_pop),
        .word       (w_acc_word),
        .word_valid (w_acc_valid)
    );

    // Capture the block descriptor; held untouched until the next accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pixels           <= in_pixels;
            r_hdr.min          <= in_min;
            r_hdr.width        <= in_width;
            r_hdr.compressable <= in_compressable;
        end
    end

    // Residual walker: channel R..A outer, pixel 0..31 inner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch       <= '0;
            r_px       <= '0;
            r_app_done <= 1'b0;
        end else if (w_accept) begin
            r_ch       <= '0;
            r_px       <= '0;
            r_app_done <= 1'b0;
        end else if (w_append) begin
            r_px <= r_px + 5'd1;
            if (r_px == 5'd31) begin
                r_ch <= r_ch + 2'd1;
                if (r_ch == 2'd3) begin
                    r_app_done <= 1'b1;
                end
            end
        end
    end

    // Output FSM: the state names the word currently held in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_wcnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state     <= ST_HDR0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_min;
                        r_out_last  <= 1'b0;
                        r_wcnt      <= '0;
                    end
                end
                ST_HDR0: begin
                    if (out_ready) begin
                        r_state    <= ST_HDR1;
                        r_out_data <= {r_hdr.compressable, 15'd0, r_hdr.width};
                        r_out_last <= (w_npay == 6'd0);
                    end
                end
                ST_HDR1, ST_PAYLOAD: begin
                    if (w_final_hs) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (!w_stall) begin
                        r_state <= ST_PAYLOAD;
                        if (w_pop || w_raw_word) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_pop ? w_acc_word : r_pixels[r_wcnt[4:0]];
                            r_out_last  <= ((r_wcnt + 6'd1) == w_npay);
                            r_wcnt      <= r_wcnt + 6'd1;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : block_packer
`default_nettype wire

// File: tb/tb_block_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_packer
//  Purpose  : Directed self-checking bench for block_packer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_block_packer;
    import types::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    pixels_t           in_pixels;
    logic [3:0][7:0]   in_min;
    logic [3:0][3:0]   in_width;
    logic              in_compressable;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]       exp_words [0:33];
    int                exp_n;
    pixels_t           t_pix;
    logic [3:0][7:0]   t_min;
    logic [3:0][3:0]   t_wid;
    logic              t_comp;

    always #5 clk = ~clk;

    block_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pixels       (in_pixels),
        .in_min          (in_min),
        .in_width        (in_width),
        .in_compressable (in_compressable),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_chan(input pixel_t p, input int ch);
        if (ch == 0) return p.r;
        if (ch == 1) return p.g;
        if (ch == 2) return p.b;
        return p.a;
    endfunction

    // Reference model: serialise residuals bit by bit into a flat stream.
    task automatic build_model();
        logic [1023:0] bits;
        logic [7:0]    res;
        int            pos;
        exp_words[0] = t_min;
        exp_words[1] = {t_comp, 15'd0, t_wid};
        if (!t_comp) begin
            for (int k = 0; k < 32; k++) exp_words[k+2] = t_pix[k];
            exp_n = 34;
        end else begin
            bits = '0;
            pos  = 0;
            for (int ch = 0; ch < 4; ch++) begin
                for (int px = 0; px < 32; px++) begin
                    res = get_chan(t_pix[px], ch) - t_min[ch];
                    for (int b = 0; b < int'(t_wid[ch]); b++) begin
                        bits[pos] = res[b];
                        pos++;
                    end
                end
            end
            exp_n = 2 + pos / 32;
            for (int w = 0; w < pos / 32; w++) exp_words[w+2] = bits[w*32 +: 32];
        end
    endtask

    // Present the descriptor in t_*; returns at the first negedge after accept.
    task automatic send_block();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_val("in_ready_timeout", 32'd0, 32'd1);
        in_valid        = 1'b1;
        in_pixels       = t_pix;
        in_min          = t_min;
        in_width        = t_wid;
        in_compressable = t_comp;
        @(posedge clk);
        @(negedge clk);
        in_valid        = 1'b0;
        for (int i = 0; i < 32; i++) in_pixels[i] = $urandom;
        in_min          = $urandom;
        in_width        = '0;
        in_compressable = ~t_comp;
    endtask

    // Drain one block, comparing each handshaked word against exp_words.
    task automatic collect(input bit rnd, input int rst_after, output int cycles);
        int          idx  = 0;
        bit          done = 1'b0;
        logic        pv   = 1'b0;
        logic        pr   = 1'b1;
        logic [31:0] pd   = '0;
        logic        pl   = 1'b0;
        cycles = 0;
        check_val("hdr0_latency_valid", 32'(out_valid), 32'd1);
        while (!done && cycles < 600) begin
            if (pv && !pr) begin
                check_val("stall_data", out_data, pd);
                check_val("stall_last", 32'(out_last), 32'(pl));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (idx < exp_n) begin
                    check_val($sformatf("word%0d", idx), out_data, exp_words[idx]);
                    check_val($sformatf("last%0d", idx), 32'(out_last), 32'(idx == exp_n - 1));
                end else begin
                    check_val("extra_word", 32'(idx), 32'(exp_n));
                end
                if (out_last) done = 1'b1;
                idx++;
                if (rst_after != 0 && idx == rst_after) begin
                    @(posedge clk);
                    #2 rst_n = 1'b0;
                    #1;
                    check_val("rst_out_valid", 32'(out_valid), 32'd0);
                    check_val("rst_in_ready", 32'(in_ready), 32'd1);
                    check_val("rst_out_data", out_data, 32'd0);
                    check_val("rst_out_last", 32'(out_last), 32'd0);
                    @(negedge clk);
                    rst_n     = 1'b1;
                    out_ready = 1'b1;
                    return;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (!done) check_val("block_timeout", 32'd0, 32'd1);
        check_val("word_count", 32'(idx), 32'(exp_n));
        check_val("post_in_ready", 32'(in_ready), 32'd1);
        check_val("post_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic make_raw();
        for (int i = 0; i < 32; i++) t_pix[i] = $urandom;
        t_min  = $urandom;
        t_wid  = {4'd2, 4'd7, 4'd1, 4'd4};
        t_comp = 1'b0;
        build_model();
    endtask

    initial begin : main
        int cyc;
        logic [7:0] res;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_pixels       = '0;
        in_min          = '0;
        in_width        = '0;
        in_compressable = 1'b0;
        out_ready       = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_in_ready", 32'(in_ready), 32'd1);
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_out_data", out_data, 32'd0);
        check_val("reset_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant pixels, all widths zero: header words only.
        for (int i = 0; i < 32; i++) t_pix[i] = {8'd8, 8'd7, 8'd6, 8'd5};
        t_min  = {8'd8, 8'd7, 8'd6, 8'd5};
        t_wid  = '0;
        t_comp = 1'b1;
        exp_words[0] = 32'h08070605;
        exp_words[1] = 32'h80000000;
        exp_n        = 2;
        send_block();
        collect(1'b0, 0, cyc);

        // Alternating R LSB with wr=1: one payload word.
        for (int i = 0; i < 32; i++) t_pix[i] = {24'd0, 8'(i % 2)};
        t_min  = '0;
        t_wid  = {4'd0, 4'd0, 4'd0, 4'd1};
        t_comp = 1'b1;
        exp_words[0] = 32'h00000000;
        exp_words[1] = 32'h80000001;
        exp_words[2] = 32'hAAAAAAAA;
        exp_n        = 3;
        send_block();
        collect(1'b0, 0, cyc);

        // Raw block, ready held high.
        make_raw();
        send_block();
        collect(1'b0, 0, cyc);
        check_val("raw_cycles", 32'(cyc), 32'd34);

        // Widths {3,5,0,8} with random in-range residuals.
        t_wid  = {4'd8, 4'd0, 4'd5, 4'd3};
        t_comp = 1'b1;
        for (int ch = 0; ch < 4; ch++) t_min[ch] = 8'($urandom);
        for (int i = 0; i < 32; i++) begin
            res = 8'($urandom) & 8'(((9'd1 << t_wid[0]) - 9'd1)); t_pix[i].r = t_min[0] + res;
            res = 8'($urandom) & 8'(((9'd1 << t_wid[1]) - 9'd1)); t_pix[i].g = t_min[1] + res;
            t_pix[i].b = t_min[2];
            res = 8'($urandom);                                    t_pix[i].a = t_min[3] + res;
        end
        build_model();
        check_val("mixed_model_len", 32'(exp_n), 32'd18);
        send_block();
        collect(1'b0, 0, cyc);
        check_val("mixed_cycle_budget", 32'(cyc <= 131), 32'd1);

        // Same block again under random backpressure.
        send_block();
        collect(1'b1, 0, cyc);

        // Fresh raw block under random backpressure.
        make_raw();
        send_block();
        collect(1'b1, 0, cyc);

        // Raw block aborted by reset after the fifth word.
        make_raw();
        send_block();
        collect(1'b0, 5, cyc);

        // Next block after the abort starts cleanly with HDR0.
        for (int i = 0; i < 32; i++) t_pix[i] = {8'd8, 8'd7, 8'd6, 8'd5};
        t_min  = {8'd8, 8'd7, 8'd6, 8'd5};
        t_wid  = '0;
        t_comp = 1'b1;
        exp_words[0] = 32'h08070605;
        exp_words[1] = 32'h80000000;
        exp_n        = 2;
        send_block();
        collect(1'b0, 0, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_block_packer
`default_nettype wire

// File: doc/block_packer.md
# block_packer

Downstream of the min/max and residual stage: accepts one 32-pixel RGBA block plus its header (per-channel minimums, per-channel residual bit widths, compressable flag) and serializes it into a stream of 32-bit words under valid/ready flow control. Compressable blocks are emitted as two header words plus bit-packed residuals. Non-compressable blocks are emitted as two header words plus 32 raw pixel words. Output feeds the link/FIFO toward the sender.

## Interface
- NUM_PIXELS, 32, pixels per block (fixed by `types::pixels_t`)
- WORD_W, 32, output word width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  block descriptor valid
- in_ready  out  1  block accepted on `in_valid && in_ready`
- in_pixels  in  types::pixels_t  32 pixels × {r,g,b,a} bytes
- in_min  in  4×8  r_min, g_min, b_min, a_min
- in_width  in  4×4  wr, wg, wb, wa; each in 0..8; bits needed for (max − min)
- in_compressable  in  1  residual stage verdict
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts on `out_valid && out_ready`
- out_data  out  32  packed word
- out_last  out  1  final word of block, qualified by out_valid

## Operation
- The block captures all inputs into internal registers on the accept handshake. Inputs are don't-care afterward.
- FSM states: IDLE → HDR0 → HDR1 → PAYLOAD → IDLE.
- IDLE: `in_ready` = 1. Accept moves the FSM to HDR0.
- HDR0 word: `{a_min, b_min, g_min, r_min}`, with r_min in [7:0].
- HDR1 word: `{compressable, 15'b0, wa, wb, wg, wr}`, with wr in [3:0].
- Compressable path:
  - Residual = pixel − channel min, truncated to the channel width.
  - Order: channel R, G, B, A; within each channel, pixel 0..31.
  - Each residual is appended at the accumulator MSB end of the valid bits, LSB-first.
  - A word is emitted as accumulator[31:0].
  - A width-0 channel contributes nothing.
  - Payload word count = wr + wg + wb + wa (0..32), exact, with no padding.
- Non-compressable path: 32 payload words, pixel i = `{a, b, g, r}`. Widths are still reported in HDR1.
- `out_last` asserts on the final word:
  - HDR1 if the payload count is 0;
  - otherwise the last payload word.
- Widths > 8 are illegal. Behaviour is undefined and may be checked by assertion.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_last` = 0, accumulator fill = 0.
- Latency: HDR0 is presented with `out_valid` = 1 in the cycle after the accept.
- Throughput, compressable path:
  - at most one residual is appended per cycle;
  - a word is valid when fill ≥ 32;
  - an append may coincide with a word handshake (shift right 32, fill −= 32, then append);
  - fill never exceeds 39;
  - a block takes ≤ 2 + 128 + 1 cycles with `out_ready` held at 1.
- Throughput, raw path: one word per cycle.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` are held stable and no residual is appended.
- The FSM returns to IDLE after the `out_last` handshake; `in_ready` is 1 in the following cycle. There is no overlap between blocks.
- Reset asserted mid-block: the in-flight block is discarded and all outputs take their reset values immediately (asynchronous).

## Structure
- Add to `types`:
  - `pack_hdr_t` (min values, widths, compressable);
  - constants `NUM_PIXELS`, `WORD_W`, `MAX_CH_W` = 8;
  - FSM enum `pack_state_t`.
- One sub-module, `bit_accumulator`, owns the 40-bit register, fill count, append, and 32-bit pop.
- Top level owns the FSM, the channel/pixel indices (2-bit and 5-bit), and the word counter.

## Test plan
- All 32 pixels = {5,6,7,8}, widths 0, compressable = 1:
  - exactly 2 words, 0x08070605 then 0x80000000;
  - `out_last` on word 2.
- R alternates 0/1 starting at pixel 0, G/B/A constant 0, wr = 1, compressable = 1:
  - 3 words total;
  - payload 0xAAAAAAAA with `out_last`.
- Pixels random, compressable = 0:
  - 34 words;
  - word k+2 = `{a,b,g,r}` of pixel k;
  - `out_last` only on word 34.
- Widths {3,5,0,8}, random residuals:
  - 18 words total;
  - payload matches a bench bit-packing model.
- `out_ready` toggled pseudo-randomly (½ duty):
  - identical word sequence to the ready-high run;
  - `out_data` stable on every stalled cycle.
- Reset asserted after word 5 of a raw block:
  - `out_valid` = 0 immediately, `in_ready` = 1;
  - the next block starts cleanly with HDR0.
